quant_stream: RTL and testbench
===============================

Name: quant_stream

Overview:
- Coefficient-serial DCT quantizer for the JPEG encoder.
- Replaces the fixed-table, 64-wide parallel quantizers with one parametrised engine serving Y, Cb and Cr.
- Takes zig-zag or raster-ordered DCT coefficients over a valid/ready stream, one coefficient per beat.
- Multiplies each coefficient by a runtime-loadable reciprocal, rounds symmetrically, saturates, and emits the results downstream toward the Huffman stage.

Parameters:
- IN_W, 11, signed input coefficient width.
- OUT_W, 11, signed quantized output width.
- FRAC, 12, reciprocal fraction bits; the reciprocal is round(2^FRAC / Q).
- RECIP_W, 13, reciprocal storage width; must be at least FRAC+1.
- NUM_TBL, 3, number of quantization tables, selected per block.
- TBL_SEL_W, 2, width of the table selects; must be at least clog2(NUM_TBL).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tbl_wr_en  in  1  table write strobe
- tbl_wr_sel  in  TBL_SEL_W  table written
- tbl_wr_addr  in  6  coefficient index 0..63 written
- tbl_wr_data  in  RECIP_W  reciprocal value
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  IN_W  signed DCT coefficient
- in_sel  in  TBL_SEL_W  table for this block; sampled on index-0 beat only
- in_last  in  1  marks coefficient 63
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  signed quantized coefficient
- out_last  out  1  marks coefficient 63 of the block
- out_sat  out  1  this beat was clipped
- err_framing  out  1  sticky framing error

Behaviour:
- Reset: one clock, synchronous, active-high reset (clk, rst).
  - Reset values: out_valid=0, out_data=0, out_last=0, out_sat=0, err_framing=0, in_ready=1.
  - Index counter=0, all pipeline valids=0.
  - All table entries = 2^FRAC (Q=1).
  - Reset mid-block discards all in-flight beats; the next accepted beat is index 0.
- Index counter:
  - 6-bit, increments on each accepted beat, wraps 63->0.
  - The block table select is latched from in_sel when an index-0 beat is accepted and held for indices 1..63.
  - in_sel >= NUM_TBL is treated as table 0.
- Framing:
  - in_last must coincide with index 63.
  - in_last at index != 63: err_framing set (sticky until rst); counter forced to 0 for the next beat.
  - Index 63 without in_last: err_framing set; counter wraps normally.
  - out_last mirrors the accepted in_last, not the counter.
- Pipeline, 3 stages:
  - S1: register coefficient, index, table select, last.
  - S2: table read; form |coef| * recip, an unsigned (IN_W+RECIP_W)-bit product.
  - S3: add 2^(FRAC-1), shift right FRAC, restore sign (round half away from zero), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 when clipped.
  - Magnitude of -2^(IN_W-1) is computed at IN_W+1 bits with no overflow.
- Latency and throughput:
  - Latency is 3 cycles from acceptance to out_valid with no stall.
  - Throughput is 1 beat per cycle.
- Flow control:
  - Global stall: all stages advance when !out_valid || out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - While out_valid && !out_ready: out_data, out_last and out_sat hold stable; no beat is lost or duplicated.
- Table writes:
  - A write is 1 cycle; tbl_wr_sel >= NUM_TBL is ignored.
  - A write in cycle N affects beats whose S2 read occurs in cycle N+1 or later.
  - Write and read of the same entry in the same cycle: the read returns the old value.
  - Writes are allowed at any time, including during a stall.

Test Plan:
- Default tables, in_data=+100, -100, +1023, -1024 -> out_data +100, -100, +1023, -1024; out_sat=0; out_valid exactly 3 cycles after each accept.
- Load table 1, addr 0, recip=256 (Q=16); block sel=1; coef0 = +24, -24, +23 -> out +2, -2, +1. This checks half-away-from-zero rounding: 24/16=1.5 -> 2, -1.5 -> -2, 23/16=1.4375 -> 1.
- Load recip=8191 at table 2 addr 5 (FRAC=12); coef5=+1000 -> product rounds to 2000, saturates to +1023 with out_sat=1; coef5=-1000 -> -1024, out_sat=1.
- Stream two 64-beat blocks back-to-back with out_ready toggling 1,0,0,1 pseudo-randomly -> 128 outputs in order, no drops or duplicates, out_last only on beats 63 and 127, outputs stable during stalls.
- in_last asserted on beat 40 -> err_framing=1 and stays 1; the next beat is treated as index 0 and uses a newly latched in_sel; rst clears err_framing.
- Table write to (sel 0, addr 0) in the same cycle that coef index 0 is in S2 -> that beat uses the old recip and the following block uses the new one. Assert rst mid-block -> out_valid=0 next cycle, and the first post-reset beat is index 0 with default tables.

Source files
------------

// File: rtl/quant_stream.sv
// Coefficient-serial DCT quantizer: multiplies by a per-table reciprocal, rounds half away
// from zero, saturates. Three-stage pipeline under a single global stall.
module quant_stream #(
    parameter int IN_W      = 11,
    parameter int OUT_W     = 11,
    parameter int FRAC      = 12,
    parameter int RECIP_W   = 13,
    parameter int NUM_TBL   = 3,
    parameter int TBL_SEL_W = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tbl_wr_en,
    input  logic [TBL_SEL_W-1:0]        i_tbl_wr_sel,
    input  logic [5:0]                  i_tbl_wr_addr,
    input  logic [RECIP_W-1:0]          i_tbl_wr_data,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic signed [IN_W-1:0]      i_in_data,
    input  logic [TBL_SEL_W-1:0]        i_in_sel,
    input  logic                        i_in_last,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic signed [OUT_W-1:0]     o_out_data,
    output logic                        o_out_last,
    output logic                        o_out_sat,
    output logic                        o_err_framing
);

    localparam int PROD_W = IN_W + RECIP_W;
    localparam int Q_W    = PROD_W + 1 - FRAC;

    localparam logic [RECIP_W-1:0]      RECIP_ONE = RECIP_W'(1) << FRAC;
    localparam logic [PROD_W:0]         HALF      = (PROD_W + 1)'(1) << (FRAC - 1);
    localparam logic [Q_W-1:0]          POS_LIM   = Q_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [Q_W-1:0]          NEG_LIM   = Q_W'(1 << (OUT_W - 1));
    localparam logic signed [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [RECIP_W-1:0] r_tbl [NUM_TBL][64];

    logic [5:0]           r_idx;
    logic [TBL_SEL_W-1:0] r_blk_sel;
    logic                 r_err;

    logic                   r_s1_valid;
    logic signed [IN_W-1:0] r_s1_coef;
    logic [5:0]             r_s1_idx;
    logic [TBL_SEL_W-1:0]   r_s1_sel;
    logic                   r_s1_last;

    logic              r_s2_valid;
    logic [PROD_W-1:0] r_s2_prod;
    logic              r_s2_neg;
    logic              r_s2_last;

    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_last;
    logic                    r_out_sat;

    logic                    w_adv;
    logic                    w_acc;
    logic                    w_idx_last;
    logic                    w_wr_ok;
    logic [TBL_SEL_W-1:0]    w_sel_in;
    logic [TBL_SEL_W-1:0]    w_blk_sel;
    logic                    w_s1_neg;
    logic [IN_W:0]           w_s1_ext;
    logic [IN_W:0]           w_s1_mag;
    logic [RECIP_W-1:0]      w_s1_recip;
    logic [PROD_W-1:0]       w_s1_prod;
    logic [Q_W-1:0]          w_s2_q;
    logic signed [OUT_W-1:0] w_s2_data;
    logic                    w_s2_sat;

    always_comb begin
        w_adv      = !r_out_valid || i_out_ready;
        w_acc      = i_in_valid && w_adv;
        w_idx_last = (r_idx == 6'd63);
        w_wr_ok    = i_tbl_wr_en && (32'(i_tbl_wr_sel) < NUM_TBL);
        w_sel_in   = (32'(i_in_sel) < NUM_TBL) ? i_in_sel : '0;
        w_blk_sel  = (r_idx == 6'd0) ? w_sel_in : r_blk_sel;
    end

    // Magnitude at IN_W+1 bits so the most negative coefficient does not overflow.
    always_comb begin
        w_s1_neg   = r_s1_coef[IN_W-1];
        w_s1_ext   = {r_s1_coef[IN_W-1], r_s1_coef};
        w_s1_mag   = w_s1_neg ? (~w_s1_ext + 1'b1) : w_s1_ext;
        w_s1_recip = r_tbl[r_s1_sel][r_s1_idx];
        w_s1_prod  = PROD_W'(w_s1_mag) * PROD_W'(w_s1_recip);
    end

    always_comb begin
        w_s2_q    = Q_W'(({1'b0, r_s2_prod} + HALF) >> FRAC);
        w_s2_sat  = 1'b0;
        w_s2_data = '0;
        if (r_s2_neg) begin
            if (w_s2_q > NEG_LIM) begin
                w_s2_sat  = 1'b1;
                w_s2_data = OUT_MIN;
            end else begin
                w_s2_data = OUT_W'(~w_s2_q + 1'b1);
            end
        end else begin
            if (w_s2_q > POS_LIM) begin
                w_s2_sat  = 1'b1;
                w_s2_data = OUT_MAX;
            end else begin
                w_s2_data = OUT_W'(w_s2_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < NUM_TBL; t++) begin
                for (int a = 0; a < 64; a++) begin
                    r_tbl[t][a] <= RECIP_ONE;
                end
            end
            r_idx       <= '0;
            r_blk_sel   <= '0;
            r_err       <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_coef   <= '0;
            r_s1_idx    <= '0;
            r_s1_sel    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_neg    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            // The S2 read samples the table before this write lands, so it sees the old value.
            if (w_wr_ok) begin
                r_tbl[i_tbl_wr_sel][i_tbl_wr_addr] <= i_tbl_wr_data;
            end

            if (w_acc) begin
                if (i_in_last && !w_idx_last) begin
                    r_err <= 1'b1;
                    r_idx <= '0;
                end else begin
                    if (w_idx_last && !i_in_last) begin
                        r_err <= 1'b1;
                    end
                    r_idx <= r_idx + 6'd1;
                end
                if (r_idx == 6'd0) begin
                    r_blk_sel <= w_sel_in;
                end
            end

            if (w_adv) begin
                r_s1_valid <= w_acc;
                if (w_acc) begin
                    r_s1_coef <= i_in_data;
                    r_s1_idx  <= r_idx;
                    r_s1_sel  <= w_blk_sel;
                    r_s1_last <= i_in_last;
                end

                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_prod <= w_s1_prod;
                    r_s2_neg  <= w_s1_neg;
                    r_s2_last <= r_s1_last;
                end

                r_out_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_out_data <= w_s2_data;
                    r_out_last <= r_s2_last;
                    r_out_sat  <= w_s2_sat;
                end
            end
        end
    end

    assign o_in_ready    = w_adv;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_last    = r_out_last;
    assign o_out_sat     = r_out_sat;
    assign o_err_framing = r_err;

endmodule

// File: tb/tb_quant_stream.sv
// Directed bench for quant_stream: rounding, saturation, framing, stalls, table-write timing.
module tb_quant_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               tbl_wr_en;
    logic [1:0]         tbl_wr_sel;
    logic [5:0]         tbl_wr_addr;
    logic [12:0]        tbl_wr_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] in_data;
    logic [1:0]         in_sel;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [10:0] out_data;
    logic               out_last;
    logic               out_sat;
    logic               err_framing;

    typedef struct {
        logic signed [10:0] data;
        logic               last;
        logic               sat;
    } beat_t;

    beat_t q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    quant_stream dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tbl_wr_en   (tbl_wr_en),
        .i_tbl_wr_sel  (tbl_wr_sel),
        .i_tbl_wr_addr (tbl_wr_addr),
        .i_tbl_wr_data (tbl_wr_data),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .i_in_sel      (in_sel),
        .i_in_last     (in_last),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_last    (out_last),
        .o_out_sat     (out_sat),
        .o_err_framing (err_framing)
    );

    always #5 clk = ~clk;

    // Handshakes are recorded at the negedge preceding the edge that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q.push_back('{out_data, out_last, out_sat});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tbl_wr_en = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic beat(input int c, input int s, input bit l);
        in_valid = 1'b1;
        in_data  = 11'(c);
        in_sel   = 2'(s);
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wr(input int s, input int a, input int d);
        tbl_wr_en   = 1'b1;
        tbl_wr_sel  = 2'(s);
        tbl_wr_addr = 6'(a);
        tbl_wr_data = 13'(d);
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        for (int i = 0; i < 400 && q.size() < n; i++) tick();
        chk(tag, q.size(), n);
    endtask

    task automatic chk_q(input string tag, input int i, input int d, input int l, input int s);
        if (q.size() > i) begin
            chk({tag, "_data"}, 32'(q[i].data), d);
            chk({tag, "_last"}, 32'(q[i].last), l);
            chk({tag, "_sat"}, 32'(q[i].sat), s);
        end else begin
            chk({tag, "_present"}, q.size(), i + 1);
        end
    endtask

    function automatic int coef(input int n);
        return ((n * 73) % 2048) - 1024;
    endfunction

    int                 vals[4] = '{100, -100, 1023, -1024};
    int                 n;
    bit                 acc;
    bit                 prev_stall;
    logic signed [10:0] prev_data;
    logic               prev_last;
    logic               prev_sat;
    logic [7:0]         lfsr;

    initial begin
        rst = 1'b1; tbl_wr_en = 1'b0; tbl_wr_sel = '0; tbl_wr_addr = '0; tbl_wr_data = '0;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0; out_ready = 1'b1;

        // Reset values and pass-through with default tables, latency 3.
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'($signed(out_data)), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_sat", 32'(out_sat), 0);
        chk("rst_err", 32'(err_framing), 0);
        chk("rst_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            beat(vals[i], 0, 1'b0);
            chk("lat_c1", 32'(out_valid), 0);
            tick();
            chk("lat_c2", 32'(out_valid), 0);
            tick();
            chk("lat_c3", 32'(out_valid), 1);
            chk("def_data", 32'($signed(out_data)), vals[i]);
            chk("def_sat", 32'(out_sat), 0);
            if (i == 0) begin
                out_ready = 1'b0;
                #1;
                chk("stall_ready", 32'(in_ready), 0);
                out_ready = 1'b1;
            end
        end

        // Q=16 rounding, half away from zero; sel latched on index 0 only.
        do_reset();
        wr(1, 0, 256); wr(1, 1, 256); wr(1, 2, 256);
        beat(24, 1, 1'b0); beat(-24, 0, 1'b0); beat(23, 0, 1'b0);
        wait_q(3, "rnd_count");
        chk_q("rnd_p15", 0, 2, 0, 0);
        chk_q("rnd_m15", 1, -2, 0, 0);
        chk_q("rnd_p14", 2, 1, 0, 0);

        // Saturation through a large reciprocal in table 2.
        do_reset();
        wr(2, 5, 8191); wr(2, 6, 8191);
        beat(0, 2, 1'b0);
        for (int i = 1; i < 5; i++) beat(0, 0, 1'b0);
        beat(1000, 0, 1'b0);
        beat(-1000, 0, 1'b0);
        wait_q(7, "sat_count");
        chk_q("sat_zero", 4, 0, 0, 0);
        chk_q("sat_pos", 5, 1023, 0, 1);
        chk_q("sat_neg", 6, -1024, 0, 1);

        // Two back-to-back blocks under random backpressure.
        do_reset();
        n = 0; lfsr = 8'hA5; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0; prev_sat = 1'b0;
        for (int cyc = 0; cyc < 1500 && q.size() < 128; cyc++) begin
            if (prev_stall) begin
                chk("hold_data", 32'($signed(out_data)), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
                chk("hold_sat", 32'(out_sat), 32'(prev_sat));
            end
            lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_ready = lfsr[0];
            in_valid  = (n < 128);
            in_data   = 11'(coef(n));
            in_sel    = 2'd0;
            in_last   = (n % 64 == 63);
            #1;
            acc        = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_sat   = out_sat;
            tick();
            if (acc) n++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        chk("strm_count", q.size(), 128);
        for (int i = 0; i < 128 && i < q.size(); i++) begin
            chk("strm_data", 32'(q[i].data), coef(i));
            chk("strm_last", 32'(q[i].last), (i % 64 == 63) ? 1 : 0);
        end
        chk("strm_err", 32'(err_framing), 0);

        // Early in_last: sticky error, next beat restarts at index 0 with a new select.
        do_reset();
        wr(1, 0, 2048);
        beat(100, 0, 1'b0);
        for (int i = 1; i <= 40; i++) beat(i, 0, (i == 40));
        chk("frm_err_set", 32'(err_framing), 1);
        beat(100, 1, 1'b0);
        beat(5, 0, 1'b0);
        wait_q(43, "frm_count");
        chk_q("frm_b0", 0, 100, 0, 0);
        chk_q("frm_b40", 40, 40, 1, 0);
        chk_q("frm_new0", 41, 50, 0, 0);
        chk_q("frm_new1", 42, 5, 0, 0);
        chk("frm_err_hold", 32'(err_framing), 1);
        do_reset();
        chk("frm_err_clr", 32'(err_framing), 0);

        // Table write while index 0 sits in S1 (read at the same edge): old value used.
        wr(1, 1, 1024);
        beat(100, 0, 1'b0);
        tbl_wr_en = 1'b1; tbl_wr_sel = 2'd0; tbl_wr_addr = 6'd0; tbl_wr_data = 13'd2048;
        tick();
        tbl_wr_en = 1'b0;
        for (int i = 1; i < 64; i++) beat(1, 0, (i == 63));
        beat(100, 0, 1'b0);
        wait_q(65, "wrt_count");
        chk_q("wrt_old", 0, 100, 0, 0);
        chk_q("wrt_last", 63, 1, 1, 0);
        chk_q("wrt_new", 64, 50, 0, 0);

        // Reset with the pipeline full.
        for (int i = 0; i < 5; i++) beat(3, 0, 1'b0);
        chk("mid_busy", 32'(out_valid), 1);
        do_reset();
        chk("mid_valid", 32'(out_valid), 0);
        wr(1, 0, 2048);
        beat(100, 1, 1'b0);
        beat(100, 0, 1'b0);
        wait_q(2, "post_count");
        chk_q("post_idx0", 0, 50, 0, 0);
        chk_q("post_deftbl", 1, 100, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("post_nodup", q.size(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
